// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's requester, register-file write port and
// issue/scoreboard signals. The slave modport is the arbiter's view.
interface wb_arbiter_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int REG_NUM        = 32
);
    logic [2:0]                    req_valid_in;
    logic [2:0]                    req_ready_out;
    logic [3*REG_ADDR_WIDTH-1:0]   req_addr_in;
    logic [3*REG_WIDTH-1:0]        req_data_in;

    logic                          reg_wr_en_out;
    logic [REG_ADDR_WIDTH-1:0]     reg_wr_addr_out;
    logic [REG_WIDTH-1:0]          reg_wr_data_out;

    logic                          issue_en_in;
    logic [REG_ADDR_WIDTH-1:0]     issue_addr_in;
    logic                          issue_stall_out;
    logic [REG_NUM-1:0]            busy_vec_out;

    modport slave (
        input  req_valid_in, req_addr_in, req_data_in, issue_en_in, issue_addr_in,
        output req_ready_out, reg_wr_en_out, reg_wr_addr_out, reg_wr_data_out,
        issue_stall_out, busy_vec_out
    );

    modport master (
        output req_valid_in, req_addr_in, req_data_in, issue_en_in, issue_addr_in,
        input  req_ready_out, reg_wr_en_out, reg_wr_addr_out, reg_wr_data_out,
        issue_stall_out, busy_vec_out
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter for ALU/LSU/CSR with a registered register-file
// write port and a busy-bit scoreboard that gates instruction issue.
module wb_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int REG_NUM        = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        PTR_ALU = 2'd0,
        PTR_LSU = 2'd1,
        PTR_CSR = 2'd2
    } ptr_e;

    ptr_e                       ptr_q, ptr_d;
    logic [REG_ADDR_WIDTH-1:0]  req_addr [3];
    logic [REG_WIDTH-1:0]       req_data [3];
    logic [2:0]                 grant;
    logic [1:0]                 gnt_idx;
    logic                       xfer;

    logic                       wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [REG_WIDTH-1:0]       wr_data_q, wr_data_d;

    logic [REG_NUM-1:0]         busy_q, busy_d;
    logic [REG_NUM-1:0]         issue_hit;
    logic [REG_NUM-1:0]         set_vec;
    logic [REG_NUM-1:0]         clr_vec;
    logic                       issue_stall;
    logic                       issue_acc;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign req_addr[gi] = bus.req_addr_in[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            assign req_data[gi] = bus.req_data_in[gi*REG_WIDTH +: REG_WIDTH];
        end
    endgenerate

    // Walk the three requesters starting at the pointer, wrapping 2 -> 0.
    always_comb begin
        grant   = 3'b000;
        gnt_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            logic [2:0] sum;
            logic [1:0] cand;
            sum  = {1'b0, ptr_q} + 3'(k);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (grant == 3'b000 && bus.req_valid_in[cand]) begin
                grant[cand] = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

    assign xfer = |grant;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            case (gnt_idx)
                2'd0:    ptr_d = PTR_LSU;
                2'd1:    ptr_d = PTR_CSR;
                default: ptr_d = PTR_ALU;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        wr_en_d   = xfer;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            wr_addr_d = req_addr[gnt_idx];
            wr_data_d = req_data[gnt_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Scoreboard: retire clears at transfer time; an accepted issue sets and
    // wins over a same-cycle retire. Register 0 is never tracked.
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_busy
            assign issue_hit[gi] = busy_q[gi] && (bus.issue_addr_in == REG_ADDR_WIDTH'(gi));
            assign set_vec[gi]   = issue_acc && (bus.issue_addr_in == REG_ADDR_WIDTH'(gi));
            assign clr_vec[gi]   = xfer && (req_addr[gnt_idx] == REG_ADDR_WIDTH'(gi));
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    assign issue_stall = bus.issue_en_in && (|issue_hit);
    assign issue_acc   = bus.issue_en_in && !issue_stall && (bus.issue_addr_in != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.req_ready_out   = grant;
    assign bus.reg_wr_en_out   = wr_en_q;
    assign bus.reg_wr_addr_out = wr_addr_q;
    assign bus.reg_wr_data_out = wr_data_q;
    assign bus.issue_stall_out = issue_stall;
    assign bus.busy_vec_out    = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected grants and register-file writes are
// queued by the stimulus and checked by a negedge monitor.
module tb_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RN = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [2:0]    exp_gnt_q  [$];
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];

    wb_arbiter_if #(.REG_ADDR_WIDTH(AW), .REG_WIDTH(DW), .REG_NUM(RN)) bus ();

    wb_arbiter #(.REG_ADDR_WIDTH(AW), .REG_WIDTH(DW), .REG_NUM(RN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One clock cycle of stimulus; er/es/eb are the hand-computed grant,
    // stall and busy vector for this cycle.
    task automatic cyc(input logic [2:0] v,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic ien, input logic [AW-1:0] ia,
                       input logic [2:0] er, input logic es, input logic [RN-1:0] eb,
                       input bit push_wr);
        @(posedge clk);
        #1;
        bus.req_valid_in  = v;
        bus.req_addr_in   = {a2, a1, a0};
        bus.req_data_in   = {d2, d1, d0};
        bus.issue_en_in   = ien;
        bus.issue_addr_in = ia;
        if (er != 3'b000) exp_gnt_q.push_back(er);
        if (push_wr) begin
            case (er)
                3'b001:  begin exp_addr_q.push_back(a0); exp_data_q.push_back(d0); end
                3'b010:  begin exp_addr_q.push_back(a1); exp_data_q.push_back(d1); end
                3'b100:  begin exp_addr_q.push_back(a2); exp_data_q.push_back(d2); end
                default: ;
            endcase
        end
        #2;
        chk("stall", 32'(bus.issue_stall_out), 32'(es));
        chk("busy",  32'(bus.busy_vec_out),    32'(eb));
        $display("cycle valid=%b issue=%b/%0d exp_grant=%b busy=%h stall=%b",
                 v, ien, ia, er, bus.busy_vec_out, bus.issue_stall_out);
    endtask

    task automatic idle(input logic [RN-1:0] eb);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0, 3'b000, 1'b0, eb, 1'b1);
    endtask

    always @(negedge clk) begin
        if (bus.req_ready_out != 3'b000) begin
            checks++;
            if (exp_gnt_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected got %b expected none", bus.req_ready_out);
            end else begin
                logic [2:0] eg;
                eg = exp_gnt_q.pop_front();
                if (bus.req_ready_out !== eg) begin
                    errors++;
                    $display("FAIL grant got %b expected %b", bus.req_ready_out, eg);
                end
            end
        end
        if (bus.reg_wr_en_out) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr %0d data %h expected none",
                         bus.reg_wr_addr_out, bus.reg_wr_data_out);
            end else begin
                logic [AW-1:0] ea;
                logic [DW-1:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (bus.reg_wr_addr_out !== ea || bus.reg_wr_data_out !== ed) begin
                    errors++;
                    $display("FAIL write got addr %0d data %h expected addr %0d data %h",
                             bus.reg_wr_addr_out, bus.reg_wr_data_out, ea, ed);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid_in  = 3'b000;
        bus.req_addr_in   = '0;
        bus.req_data_in   = '0;
        bus.issue_en_in   = 1'b0;
        bus.issue_addr_in = '0;

        // Reset state, and grant still follows p=0 while in reset.
        #2;
        bus.req_valid_in = 3'b110;
        #1;
        chk("rst_ready", 32'(bus.req_ready_out),   32'h2);
        chk("rst_wr_en", 32'(bus.reg_wr_en_out),   32'h0);
        chk("rst_addr",  32'(bus.reg_wr_addr_out), 32'h0);
        chk("rst_data",  bus.reg_wr_data_out,      32'h0);
        chk("rst_busy",  bus.busy_vec_out,         32'h0);
        bus.req_valid_in = 3'b000;
        #19;
        rst = 1'b0;

        // Single ALU request, then idle and hold checks.
        cyc(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 1'b0, 0, 3'b001, 1'b0, 32'h0, 1'b1);
        idle(32'h0);
        idle(32'h0);
        chk("hold_wr_en", 32'(bus.reg_wr_en_out),   32'h0);
        chk("hold_addr",  32'(bus.reg_wr_addr_out), 32'h5);
        chk("hold_data",  bus.reg_wr_data_out,      32'hDEADBEEF);

        // Write to x0 from CSR (pointer is at LSU, CSR wins), pointer returns to 0.
        cyc(3'b100, 0, 0, 0, 0, 0, 32'h1234, 1'b0, 0, 3'b100, 1'b0, 32'h0, 1'b1);

        // Contention: all three valid, rotation 001,010,100,001.
        cyc(3'b111, 1, 2, 3, 32'hA1, 32'hB2, 32'hC3, 1'b0, 0, 3'b001, 1'b0, 32'h0, 1'b1);
        cyc(3'b111, 1, 2, 3, 32'hA1, 32'hB2, 32'hC3, 1'b0, 0, 3'b010, 1'b0, 32'h0, 1'b1);
        cyc(3'b111, 1, 2, 3, 32'hA1, 32'hB2, 32'hC3, 1'b0, 0, 3'b100, 1'b0, 32'h0, 1'b1);
        cyc(3'b111, 1, 2, 3, 32'hA1, 32'hB2, 32'hC3, 1'b0, 0, 3'b001, 1'b0, 32'h0, 1'b1);
        idle(32'h0);

        // Scoreboard: issue 7, reissue stalls, LSU retires 7, issue to x0 ignored.
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 7, 3'b000, 1'b0, 32'h0, 1'b1);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 7, 3'b000, 1'b1, 32'h80, 1'b1);
        cyc(3'b010, 0, 7, 0, 0, 32'h77, 0, 1'b0, 0, 3'b010, 1'b0, 32'h80, 1'b1);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 0, 3'b000, 1'b0, 32'h0, 1'b1);
        idle(32'h0);

        // Collisions: stalled issue with retire clears; accepted issue beats retire;
        // issue 3 with retire 9 applies both.
        cyc(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 9, 3'b000, 1'b0, 32'h0, 1'b1);
        cyc(3'b001, 9, 0, 0, 32'h99, 0, 0, 1'b1, 9, 3'b001, 1'b1, 32'h200, 1'b1);
        cyc(3'b001, 9, 0, 0, 32'h9A, 0, 0, 1'b1, 9, 3'b001, 1'b0, 32'h0, 1'b1);
        cyc(3'b001, 9, 0, 0, 32'h9B, 0, 0, 1'b1, 3, 3'b001, 1'b0, 32'h200, 1'b1);
        idle(32'h008);

        // Transfer, then asynchronous reset mid-cycle discards the registered write.
        cyc(3'b010, 0, 12, 0, 0, 32'hCAFE, 0, 1'b0, 0, 3'b010, 1'b0, 32'h008, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid_in = 3'b000;
        chk("pre_rst_wr_en", 32'(bus.reg_wr_en_out),   32'h1);
        chk("pre_rst_addr",  32'(bus.reg_wr_addr_out), 32'd12);
        chk("pre_rst_data",  bus.reg_wr_data_out,      32'hCAFE);
        #1;
        rst = 1'b1;
        #1;
        chk("async_wr_en", 32'(bus.reg_wr_en_out),   32'h0);
        chk("async_addr",  32'(bus.reg_wr_addr_out), 32'h0);
        chk("async_data",  bus.reg_wr_data_out,      32'h0);
        chk("async_busy",  bus.busy_vec_out,         32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // After release the pointer is 0, so 110 grants LSU.
        cyc(3'b110, 0, 4, 6, 0, 32'h44, 32'h66, 1'b0, 0, 3'b010, 1'b0, 32'h0, 1'b1);
        idle(32'h0);
        idle(32'h0);

        chk("grant_queue_left", 32'(exp_gnt_q.size()),  32'h0);
        chk("write_queue_left", 32'(exp_addr_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-002 Parameter REG_WIDTH, default 32, register data width.
REQ-003 Parameter REG_NUM, default 32, number of architectural registers.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid_in  input  3  per-requester write request: bit0 ALU, bit1 LSU, bit2 CSR.
REQ-007 req_ready_out  output  3  per-requester grant; one-hot or zero.
REQ-008 req_addr_in  input  3*REG_ADDR_WIDTH  packed destination indices; requester i at slice i.
REQ-009 req_data_in  input  3*REG_WIDTH  packed write data; requester i at slice i.
REQ-010 reg_wr_en_out  output  1  register-file write enable.
REQ-011 reg_wr_addr_out  output  REG_ADDR_WIDTH  register-file write index.
REQ-012 reg_wr_data_out  output  REG_WIDTH  register-file write data.
REQ-013 issue_en_in  input  1  decode issues an instruction with a destination register.
REQ-014 issue_addr_in  input  REG_ADDR_WIDTH  destination index of issuing instruction.
REQ-015 issue_stall_out  output  1  issue rejected this cycle (destination pending).
REQ-016 busy_vec_out  output  REG_NUM  scoreboard; bit r = write to register r pending.

Function
REQ-017 Transfer for requester i occurs in a cycle where req_valid_in[i] and req_ready_out[i] are both 1.
REQ-018 req_ready_out is combinational from req_valid_in and the round-robin pointer; at most one bit set; zero when no valid.
REQ-019 Round-robin: search order starts at pointer p (0..2), wraps 2->0; first valid requester granted.
REQ-020 On a transfer from requester i, p becomes (i+1) mod 3 at next edge; without a transfer p holds.
REQ-021 Requester holding valid without grant keeps address/data stable; arbiter never drops a pending request; worst-case wait 2 cycles.
REQ-022 Write port registered: transfer in cycle N -> reg_wr_en_out=1 with that addr/data in cycle N+1 only; otherwise reg_wr_en_out=0, addr/data hold last values.
REQ-023 Transfer to index 0 is accepted and forwarded normally (register file discards it); scoreboard bit 0 never set.
REQ-024 issue_stall_out = issue_en_in AND busy_vec_out[issue_addr_in], combinational.
REQ-025 Issue accepted when issue_en_in=1, issue_stall_out=0 and issue_addr_in!=0: busy bit set at next edge.
REQ-026 Transfer with address r clears busy bit r at next edge (retire occurs at transfer, not at port write).
REQ-027 Same-cycle accepted issue and retire of same r: set wins, bit r =1 next cycle.
REQ-028 Issue and retire on different indices in same cycle: both applied.
REQ-029 Retire to a register whose busy bit is 0: bit stays 0, write still performed.
REQ-030 Arbitration independent of scoreboard; no requester gated by busy state.

Reset
REQ-031 rst=1 forces immediately (asynchronous): p=0, busy_vec_out=0, reg_wr_en_out=0, reg_wr_addr_out=0, reg_wr_data_out=0.
REQ-032 Reset mid-operation discards pending registered write and all busy bits; req_ready_out still follows REQ-018 with p=0 while rst=1; no transfer is recorded while rst=1.
REQ-033 First edge after rst falls behaves as a normal cycle.

Verification
REQ-034 Single request: ALU valid, addr 5, data 0xDEADBEEF, p=0 -> ready=001 same cycle; next cycle wr_en=1, addr=5, data=0xDEADBEEF; following cycle wr_en=0.
REQ-035 Contention: all three valid continuously from p=0 -> grants 001,010,100,001 on consecutive cycles; write port shows ALU, LSU, CSR data in order one cycle later.
REQ-036 Scoreboard: issue addr 7 -> busy_vec_out=0x80; issue addr 7 again -> issue_stall_out=1, vector unchanged; LSU writes addr 7 -> bit 7 clears next edge; issue addr 0 -> vector unchanged.
REQ-037 Collision: busy bit 9 set, same cycle ALU retires addr 9 and issue addr 9 accepted -> bit 9 remains 1; issue 3 plus retire 9 same cycle -> vector 0x008.
REQ-038 Async reset: transfer in cycle N, rst pulsed mid-cycle N+1 -> wr_en, addr, data, busy_vec drop to 0 without clock edge; after release, valid=110 grants LSU (p=0).
REQ-039 Write to x0: CSR valid, addr 0, data 0x1234 -> transfer, wr_en=1 addr=0 next cycle, busy_vec_out bit 0 stays 0.
